traffic_ctrl_multi: RTL and testbench
=====================================

// Module: traffic_ctrl_multi
// PURPOSE
//  Parametrised successor to the single-approach light controller. Serves N_DIR approaches round-robin.
//  Each approach runs GREEN -> YELLOW -> ALL_RED. Debounced, latched pedestrian requests insert an
//  exclusive WALK phase and can shorten a green. Runs on clk_50 with an internal tick enable, so no
//  derived clock. Sits directly under the board top, driving LEDs/GPIO.
// PARAMETERS
//  CLK_HZ      50_000_000  input clock frequency
//  TICK_HZ     1           phase-timer tick rate; TICK_DIV = CLK_HZ/TICK_HZ, must be >= 2
//  N_DIR       2           number of approaches, 2..8
//  GREEN_T     10          max green length, ticks (>= MIN_GREEN)
//  MIN_GREEN   4           green ticks served before a ped request may cut green short
//  YELLOW_T    3           yellow length, ticks, >= 1
//  ALLRED_T    1           all-red clearance, ticks, >= 1
//  WALK_T      8           walk length, ticks, >= 1
//  DEB_CYC     1_000_000   clk_50 cycles a ped input must be stable high to register
// PORTS
//  clk_50      in   1              system clock
//  rst_n       in   1              asynchronous, active-low reset
//  ped_btn     in   N_DIR          raw async pedestrian buttons, one per approach
//  led_red     out  N_DIR          red lamp per approach
//  led_yellow  out  N_DIR          yellow lamp per approach
//  led_green   out  N_DIR          green lamp per approach
//  walk        out  N_DIR          walk signal per crossing
//  ped_pend    out  N_DIR          latched, not-yet-served requests
//  phase_idx   out  $clog2(N_DIR)  approach currently owning (or next owning) green
// BEHAVIOUR
//  Reset (async assert, sync release): state ALL_RED, timer=ALLRED_T, phase_idx=0.
//   led_red=all 1s, other lamps/walk/ped_pend=0, tick counter=0.
//  Tick: 1-cycle pulse every TICK_DIV cycles. Phase timers decrement only on ticks. A phase of T
//   ticks lasts exactly T*TICK_DIV cycles once aligned to the tick grid.
//  Ped input path, per bit:
//   - 2-flop synchroniser, then stability counter.
//   - Bit registers a press on the rising edge of the debounced level: a one-cycle pulse after
//     2+DEB_CYC stable-high cycles.
//   - Pulse sets ped_pend[i]. Holding the button does not re-trigger; release is needed.
//  FSM, evaluated on tick (all outputs registered, change 1 cycle after the deciding tick):
//   ALL_RED: timer 0 ->
//     - if |ped_pend: WALK, walk<=ped_pend, ped_pend cleared, timer=WALK_T
//     - else: GREEN, phase_idx<=next, timer=GREEN_T
//   GREEN:   timer 0, or (|ped_pend && served>=MIN_GREEN) -> YELLOW, timer=YELLOW_T
//   YELLOW:  timer 0 -> ALL_RED, timer=ALLRED_T
//   WALK:    timer 0 -> walk<=0, GREEN, phase_idx<=next, timer=GREEN_T
//   next = phase_idx+1, wrapping N_DIR-1 -> 0. The first GREEN after reset uses phase 0, not 1.
//  Lamps:
//   - Exactly one of red/yellow/green is set per approach in every cycle.
//   - Only approach phase_idx may be non-red.
//   - walk is nonzero only in WALK, where all approaches are red.
//  Simultaneous events:
//   - Debounced press in the same cycle ped_pend is cleared: the set wins and the bit stays pending.
//   - Presses during WALK latch for the next cycle.
//  Reset mid-phase: immediate all-red, pending requests dropped.
//  Timer width $clog2(max(GREEN_T,WALK_T,YELLOW_T,ALLRED_T)+1). Served-green counter saturates.
// STRUCTURE
//  Shared package traffic_pkg: state enum (S_ALLRED, S_GREEN, S_YELLOW, S_WALK), lamp encoding
//   constants, timing-param check function.
//  One sub-module: ped_debounce (sync + stability counter + edge pulse), instantiated N_DIR times.
//  Tick divider and FSM live inline.
// TESTING (bench params: CLK_HZ=10, TICK_HZ=1 -> TICK_DIV=10, N_DIR=3, DEB_CYC=4, other defaults)
//  1 Reset, no presses:
//    - all red for 1 tick, then G0 10 ticks, Y0 3, AR 1, G1, Y1, AR, G2, back to G0.
//    - Lamp one-hot checked every cycle.
//  2 ped_btn[1] high 6 cycles during G0 tick 2:
//    - ped_pend=3'b010 seven cycles after the press (2 sync + 4 stable + 1 reg).
//    - G0 ends after tick 4 (MIN_GREEN), then Y0, AR, WALK walk=3'b010 8 ticks, then G1.
//  3 Bounce: ped_btn toggles every 2 cycles for 40 cycles -> ped_pend stays 0.
//  4 Press on all 3 buttons during WALK -> walk unchanged; ped_pend=3'b111 and served in next WALK.
//  5 rst_n low for 3 cycles mid-YELLOW, asynchronously and off any clock edge:
//    - outputs go all-red/zero before the next clk edge.
//    - restart matches scenario 1.
//  6 Hold ped_btn[0] high 100 cycles -> exactly one request registered.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions for the multi-approach traffic controller.
//   state_t     : controller phase encoding
//   lamp_t      : one-hot {green, yellow, red} lamp code per approach
//   max4        : helper for sizing the shared phase timer
//   timing_ok   : elaboration-time sanity check of the timing parameters
package traffic_pkg;

    typedef enum logic [1:0] {
        S_ALLRED = 2'd0,
        S_GREEN  = 2'd1,
        S_YELLOW = 2'd2,
        S_WALK   = 2'd3
    } state_t;

    // Bit order {green, yellow, red}: exactly one bit set per approach.
    typedef logic [2:0] lamp_t;
    localparam lamp_t LAMP_RED    = 3'b001;
    localparam lamp_t LAMP_YELLOW = 3'b010;
    localparam lamp_t LAMP_GREEN  = 3'b100;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    function automatic bit timing_ok(input int clk_hz, input int tick_hz, input int n_dir,
                                     input int green_t, input int min_green, input int yellow_t,
                                     input int allred_t, input int walk_t, input int deb_cyc);
        return (tick_hz > 0) && (clk_hz / tick_hz >= 2) &&
               (n_dir >= 2) && (n_dir <= 8) &&
               (green_t >= 1) && (green_t >= min_green) && (min_green >= 0) &&
               (yellow_t >= 1) && (allred_t >= 1) && (walk_t >= 1) && (deb_cyc >= 1);
    endfunction

endpackage

// File: rtl/ped_debounce.sv
// Pedestrian button conditioner for a single crossing.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   btn    : raw asynchronous button level
//   press  : one-cycle pulse on the rising edge of the debounced level
// The raw input passes a 2-flop synchroniser; the debounced level rises once the
// synchronised input has been high for DEB_CYC consecutive cycles and drops on the
// first low sample, so a held button yields a single pulse until it is released.
module ped_debounce #(
    parameter int DEB_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam int CW = $clog2(DEB_CYC + 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          level_q;
    logic          level_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= '0;
            cnt_q        <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], btn};
            level_prev_q <= level_q;
            if (!sync_q[1]) begin
                cnt_q   <= '0;
                level_q <= 1'b0;
            end else if (cnt_q == CW'(DEB_CYC - 1)) begin
                // Counter parks here while held; level stays high.
                level_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign press = level_q & ~level_prev_q;

endmodule

// File: rtl/traffic_ctrl_multi.sv
// Round-robin traffic light controller for N_DIR approaches with pedestrian WALK phase.
//   clk_50      : system clock
//   rst_n       : asynchronous active-low reset
//   ped_btn     : raw pedestrian buttons, one per approach
//   led_red     : red lamp per approach
//   led_yellow  : yellow lamp per approach
//   led_green   : green lamp per approach
//   walk        : walk signal per crossing (only during the all-red WALK phase)
//   ped_pend    : latched pedestrian requests not yet served
//   phase_idx   : approach currently owning (or about to own) green
// Phase timing is driven by a 1-cycle tick enable every CLK_HZ/TICK_HZ cycles; every
// output is registered and decoded from the next state so lamps always agree with it.
module traffic_ctrl_multi
    import traffic_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int TICK_HZ   = 1,
    parameter int N_DIR     = 2,
    parameter int GREEN_T   = 10,
    parameter int MIN_GREEN = 4,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 8,
    parameter int DEB_CYC   = 1_000_000
) (
    input  logic                     clk_50,
    input  logic                     rst_n,
    input  logic [N_DIR-1:0]         ped_btn,
    output logic [N_DIR-1:0]         led_red,
    output logic [N_DIR-1:0]         led_yellow,
    output logic [N_DIR-1:0]         led_green,
    output logic [N_DIR-1:0]         walk,
    output logic [N_DIR-1:0]         ped_pend,
    output logic [$clog2(N_DIR)-1:0] phase_idx
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int TDW      = $clog2(TICK_DIV);
    localparam int TW       = $clog2(max4(GREEN_T, WALK_T, YELLOW_T, ALLRED_T) + 1);
    localparam int SW       = $clog2(MIN_GREEN + 2);
    localparam int PW       = $clog2(N_DIR);

    if (!timing_ok(CLK_HZ, TICK_HZ, N_DIR, GREEN_T, MIN_GREEN, YELLOW_T,
                   ALLRED_T, WALK_T, DEB_CYC)) begin : g_param_err
        $error("traffic_ctrl_multi: invalid timing parameters");
    end

    // ---------------------------------------------------------------- ped inputs
    logic [N_DIR-1:0] press;

    for (genvar gi = 0; gi < N_DIR; gi++) begin : g_deb
        ped_debounce #(
            .DEB_CYC (DEB_CYC)
        ) u_deb (
            .clk   (clk_50),
            .rst_n (rst_n),
            .btn   (ped_btn[gi]),
            .press (press[gi])
        );
    end

    // ---------------------------------------------------------------- tick divider
    logic [TDW-1:0] tick_cnt;
    logic           tick;

    assign tick = (tick_cnt == TDW'(TICK_DIV - 1));

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n)    tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + TDW'(1);
    end

    // ---------------------------------------------------------------- FSM
    state_t           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [SW-1:0]    served_q, served_d, served_inc;
    logic             started_q, started_d;
    logic [PW-1:0]    phase_d, phase_nxt;
    logic [N_DIR-1:0] walk_d, pend_clr, pend_d;
    logic [N_DIR-1:0] red_d, yellow_d, green_d;
    logic             last;

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_ALLRED;
            timer_q    <= TW'(ALLRED_T);
            served_q   <= '0;
            started_q  <= 1'b0;
            phase_idx  <= '0;
            walk       <= '0;
            ped_pend   <= '0;
            led_red    <= '1;
            led_yellow <= '0;
            led_green  <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            served_q   <= served_d;
            started_q  <= started_d;
            phase_idx  <= phase_d;
            walk       <= walk_d;
            ped_pend   <= pend_d;
            led_red    <= red_d;
            led_yellow <= yellow_d;
            led_green  <= green_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        served_d  = served_q;
        started_d = started_q;
        phase_d   = phase_idx;
        walk_d    = walk;
        pend_clr  = '0;

        // The tick that finds one tick left ends the phase, giving T ticks per phase.
        last       = (timer_q <= TW'(1));
        served_inc = (served_q >= SW'(MIN_GREEN)) ? served_q : served_q + SW'(1);
        // Until the first green has been granted, "next" is approach 0 itself.
        if (!started_q)                        phase_nxt = phase_idx;
        else if (phase_idx == PW'(N_DIR - 1))  phase_nxt = '0;
        else                                   phase_nxt = phase_idx + PW'(1);

        if (tick) begin
            case (state_q)
                S_ALLRED: begin
                    if (!last) begin
                        timer_d = timer_q - TW'(1);
                    end else if (|ped_pend) begin
                        state_d  = S_WALK;
                        timer_d  = TW'(WALK_T);
                        walk_d   = ped_pend;
                        pend_clr = ped_pend;
                    end else begin
                        state_d   = S_GREEN;
                        timer_d   = TW'(GREEN_T);
                        phase_d   = phase_nxt;
                        started_d = 1'b1;
                        served_d  = '0;
                    end
                end
                S_GREEN: begin
                    served_d = served_inc;
                    if (last || (|ped_pend && served_inc >= SW'(MIN_GREEN))) begin
                        state_d = S_YELLOW;
                        timer_d = TW'(YELLOW_T);
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                S_YELLOW: begin
                    if (last) begin
                        state_d = S_ALLRED;
                        timer_d = TW'(ALLRED_T);
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                S_WALK: begin
                    if (last) begin
                        state_d   = S_GREEN;
                        timer_d   = TW'(GREEN_T);
                        walk_d    = '0;
                        phase_d   = phase_nxt;
                        started_d = 1'b1;
                        served_d  = '0;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                default: begin
                    state_d = S_ALLRED;
                    timer_d = TW'(ALLRED_T);
                end
            endcase
        end

        // A fresh press in the clearing cycle survives.
        pend_d = (ped_pend & ~pend_clr) | press;
    end

    // Lamp decode from the next state so the registered lamps track state_q exactly.
    always_comb begin
        red_d    = '0;
        yellow_d = '0;
        green_d  = '0;
        for (int i = 0; i < N_DIR; i++) begin
            lamp_t lamp;
            lamp = LAMP_RED;
            if (phase_d == PW'(i)) begin
                if (state_d == S_GREEN)       lamp = LAMP_GREEN;
                else if (state_d == S_YELLOW) lamp = LAMP_YELLOW;
            end
            red_d[i]    = lamp[0];
            yellow_d[i] = lamp[1];
            green_d[i]  = lamp[2];
        end
    end

endmodule

// File: tb/tb_traffic_ctrl_multi.sv
module tb_traffic_ctrl_multi;

    localparam int N = 3;

    logic         clk_50 = 1'b0;
    logic         rst_n  = 1'b0;
    logic [N-1:0] ped_btn = '0;
    logic [N-1:0] led_red, led_yellow, led_green, walk, ped_pend;
    logic [1:0]   phase_idx;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    traffic_ctrl_multi #(
        .CLK_HZ    (10),
        .TICK_HZ   (1),
        .N_DIR     (N),
        .GREEN_T   (10),
        .MIN_GREEN (4),
        .YELLOW_T  (3),
        .ALLRED_T  (1),
        .WALK_T    (8),
        .DEB_CYC   (4)
    ) dut (
        .clk_50     (clk_50),
        .rst_n      (rst_n),
        .ped_btn    (ped_btn),
        .led_red    (led_red),
        .led_yellow (led_yellow),
        .led_green  (led_green),
        .walk       (walk),
        .ped_pend   (ped_pend),
        .phase_idx  (phase_idx)
    );

    always #5 clk_50 = ~clk_50;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance to the negedge following posedge number k since reset release.
    task automatic go_to(input int k);
        while (cyc < k) begin
            @(negedge clk_50);
            cyc++;
        end
    endtask

    task automatic do_reset();
        ped_btn = '0;
        @(negedge clk_50);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk_50);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_reset();
        ped_btn = '0;
        @(negedge clk_50);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({led_red, led_yellow, led_green, walk, ped_pend, phase_idx} !== {3'b111, 12'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL reset_outputs: got r=%b y=%b g=%b w=%b p=%b ph=%0d want r=111 rest 0",
                     led_red, led_yellow, led_green, walk, ped_pend, phase_idx);
        end
        repeat (2) @(negedge clk_50);
        rst_n = 1'b1;
        cyc   = 0;
        go_to(9);
        n_tests++;
        if ({led_red, led_green} !== {3'b111, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_allred_tick: got r=%b g=%b want r=111 g=000", led_red, led_green);
        end
        go_to(10);
        n_tests++;
        if ({led_red, led_green, phase_idx} !== {3'b110, 3'b001, 2'd0}) begin
            n_fail++;
            $display("FAIL reset_first_green: got r=%b g=%b ph=%0d want r=110 g=001 ph=0",
                     led_red, led_green, phase_idx);
        end
    endtask

    // Free-running schedule from a reset release with no presses: AR 10 cycles, then
    // per approach G 100, Y 30, AR 10 cycles; 420-cycle rotation.
    task automatic test_cycle(input string name, input int ncyc);
        logic [2:0] er, ey, eg, oh;
        logic [1:0] ep;
        int m, d, r;
        for (int k = cyc + 1; k <= ncyc; k++) begin
            @(negedge clk_50);
            cyc++;
            er = 3'b111; ey = 3'b000; eg = 3'b000; ep = 2'd0;
            if (k >= 10) begin
                m  = (k - 10) % 420;
                d  = m / 140;
                r  = m % 140;
                oh = 3'b001 << d;
                ep = 2'(d);
                if (r < 100) begin
                    eg = oh; er = ~oh;
                end else if (r < 130) begin
                    ey = oh; er = ~oh;
                end
            end
            n_tests++;
            if ({led_red, led_yellow, led_green, walk, ped_pend, phase_idx} !== {er, ey, eg, 6'b0, ep}) begin
                n_fail++;
                $display("FAIL %s cyc %0d: got r=%b y=%b g=%b w=%b p=%b ph=%0d want r=%b y=%b g=%b w=0 p=0 ph=%0d",
                         name, k, led_red, led_yellow, led_green, walk, ped_pend, phase_idx, er, ey, eg, ep);
            end
            for (int i = 0; i < N; i++) begin
                n_tests++;
                if ((int'(led_red[i]) + int'(led_yellow[i]) + int'(led_green[i])) != 1) begin
                    n_fail++;
                    $display("FAIL %s onehot cyc %0d lane %0d: got ryg=%b%b%b want exactly one set",
                             name, k, i, led_red[i], led_yellow[i], led_green[i]);
                end
            end
        end
    endtask

    task automatic test_ped_short();
        do_reset();
        go_to(25);
        ped_btn[1] = 1'b1;
        go_to(31);
        ped_btn[1] = 1'b0;
        n_tests++;
        if (ped_pend !== 3'b000) begin
            n_fail++;
            $display("FAIL ped_latency_early: got pend=%b want 000", ped_pend);
        end
        go_to(32);
        n_tests++;
        if (ped_pend !== 3'b010) begin
            n_fail++;
            $display("FAIL ped_latency: got pend=%b want 010", ped_pend);
        end
        go_to(49);
        n_tests++;
        if (led_green !== 3'b001) begin
            n_fail++;
            $display("FAIL ped_min_green_hold: got g=%b want 001", led_green);
        end
        go_to(50);
        n_tests++;
        if ({led_yellow, led_green} !== {3'b001, 3'b000}) begin
            n_fail++;
            $display("FAIL ped_cut_green: got y=%b g=%b want y=001 g=000", led_yellow, led_green);
        end
        go_to(89);
        n_tests++;
        if ({led_red, walk, ped_pend} !== {3'b111, 3'b000, 3'b010}) begin
            n_fail++;
            $display("FAIL ped_allred: got r=%b w=%b p=%b want r=111 w=000 p=010", led_red, walk, ped_pend);
        end
        go_to(90);
        n_tests++;
        if ({led_red, walk, ped_pend} !== {3'b111, 3'b010, 3'b000}) begin
            n_fail++;
            $display("FAIL ped_walk_start: got r=%b w=%b p=%b want r=111 w=010 p=000", led_red, walk, ped_pend);
        end
        go_to(169);
        n_tests++;
        if ({led_red, walk} !== {3'b111, 3'b010}) begin
            n_fail++;
            $display("FAIL ped_walk_end: got r=%b w=%b want r=111 w=010", led_red, walk);
        end
        go_to(170);
        n_tests++;
        if ({led_green, walk, phase_idx} !== {3'b010, 3'b000, 2'd1}) begin
            n_fail++;
            $display("FAIL ped_after_walk: got g=%b w=%b ph=%0d want g=010 w=000 ph=1", led_green, walk, phase_idx);
        end
    endtask

    task automatic test_bounce();
        do_reset();
        go_to(15);
        for (int j = 0; j < 20; j++) begin
            ped_btn = (j % 2 == 0) ? 3'b111 : 3'b000;
            go_to(cyc + 2);
            n_tests++;
            if (ped_pend !== 3'b000) begin
                n_fail++;
                $display("FAIL bounce_pend step %0d: got %b want 000", j, ped_pend);
            end
        end
        ped_btn = '0;
        go_to(70);
        n_tests++;
        if (ped_pend !== 3'b000) begin
            n_fail++;
            $display("FAIL bounce_settle: got pend=%b want 000", ped_pend);
        end
        go_to(109);
        n_tests++;
        if (led_green !== 3'b001) begin
            n_fail++;
            $display("FAIL bounce_full_green: got g=%b want 001", led_green);
        end
        go_to(110);
        n_tests++;
        if (led_yellow !== 3'b001) begin
            n_fail++;
            $display("FAIL bounce_yellow: got y=%b want 001", led_yellow);
        end
    endtask

    task automatic test_walk_press();
        do_reset();
        go_to(25);
        ped_btn[1] = 1'b1;
        go_to(31);
        ped_btn[1] = 1'b0;
        go_to(100);
        ped_btn = 3'b111;
        go_to(106);
        ped_btn = 3'b000;
        n_tests++;
        if (ped_pend !== 3'b000) begin
            n_fail++;
            $display("FAIL walk_press_early: got pend=%b want 000", ped_pend);
        end
        go_to(107);
        n_tests++;
        if ({walk, ped_pend} !== {3'b010, 3'b111}) begin
            n_fail++;
            $display("FAIL walk_press_latch: got w=%b p=%b want w=010 p=111", walk, ped_pend);
        end
        go_to(170);
        n_tests++;
        if ({led_green, ped_pend, phase_idx} !== {3'b010, 3'b111, 2'd1}) begin
            n_fail++;
            $display("FAIL walk_press_g1: got g=%b p=%b ph=%0d want g=010 p=111 ph=1", led_green, ped_pend, phase_idx);
        end
        go_to(210);
        n_tests++;
        if ({led_yellow, led_green} !== {3'b010, 3'b000}) begin
            n_fail++;
            $display("FAIL walk_press_cut: got y=%b g=%b want y=010 g=000", led_yellow, led_green);
        end
        go_to(250);
        n_tests++;
        if ({led_red, walk, ped_pend} !== {3'b111, 3'b111, 3'b000}) begin
            n_fail++;
            $display("FAIL walk_press_serve: got r=%b w=%b p=%b want r=111 w=111 p=000", led_red, walk, ped_pend);
        end
        go_to(330);
        n_tests++;
        if ({led_green, walk, phase_idx} !== {3'b100, 3'b000, 2'd2}) begin
            n_fail++;
            $display("FAIL walk_press_g2: got g=%b w=%b ph=%0d want g=100 w=000 ph=2", led_green, walk, phase_idx);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        go_to(112);
        ped_btn[2] = 1'b1;
        go_to(118);
        ped_btn[2] = 1'b0;
        go_to(119);
        n_tests++;
        if ({led_yellow, ped_pend} !== {3'b001, 3'b100}) begin
            n_fail++;
            $display("FAIL areset_pre: got y=%b p=%b want y=001 p=100", led_yellow, ped_pend);
        end
        go_to(120);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({led_red, led_yellow, led_green, walk, ped_pend, phase_idx} !== {3'b111, 12'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL areset_immediate: got r=%b y=%b g=%b w=%b p=%b ph=%0d want r=111 rest 0",
                     led_red, led_yellow, led_green, walk, ped_pend, phase_idx);
        end
        repeat (3) @(negedge clk_50);
        rst_n = 1'b1;
        cyc   = 0;
        test_cycle("areset_restart", 160);
    endtask

    task automatic test_hold();
        do_reset();
        go_to(15);
        ped_btn[0] = 1'b1;
        go_to(21);
        n_tests++;
        if (ped_pend !== 3'b000) begin
            n_fail++;
            $display("FAIL hold_early: got pend=%b want 000", ped_pend);
        end
        go_to(22);
        n_tests++;
        if (ped_pend !== 3'b001) begin
            n_fail++;
            $display("FAIL hold_latch: got pend=%b want 001", ped_pend);
        end
        go_to(89);
        for (int k = 90; k <= 169; k++) begin
            if (k == 115) ped_btn[0] = 1'b0;
            go_to(k);
            n_tests++;
            if ({walk, ped_pend} !== {3'b001, 3'b000}) begin
                n_fail++;
                $display("FAIL hold_single cyc %0d: got w=%b p=%b want w=001 p=000", k, walk, ped_pend);
            end
        end
        go_to(170);
        n_tests++;
        if ({led_green, walk, ped_pend} !== {3'b010, 3'b000, 3'b000}) begin
            n_fail++;
            $display("FAIL hold_after: got g=%b w=%b p=%b want g=010 w=000 p=000", led_green, walk, ped_pend);
        end
    endtask

    initial begin
        test_reset();
        do_reset();
        test_cycle("rotation", 450);
        test_ped_short();
        test_bounce();
        test_walk_press();
        test_async_reset();
        test_hold();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
